instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage between the PC and decode. Owns the program counter, which drives the combinational program ROM address.
- Latches the returned 16-bit word into an instruction register (IR) and hands it to decode over a valid/ready handshake.
- Supports branch redirect with flush, halt, and stop-at-end or wrap-around addressing.

Parameters:
- PC_W, 3, program counter / ROM address width (ROM depth = 2^PC_W).
- INSTR_W, 16, instruction width.
- WRAP_EN, 1, 1: PC wraps from 2^PC_W-1 to 0; 0: fetch stops after the last address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  PC_W  ROM address; always equals the current PC.
- rom_instr  in  INSTR_W  ROM data; combinational from rom_addr, same cycle.
- ir_out  out  INSTR_W  instruction register contents presented to decode.
- ir_pc  out  PC_W  address the IR word was fetched from.
- ir_valid  out  1  IR holds an instruction not yet consumed.
- dec_ready  in  1  decode accepts IR this cycle.
- branch_en  in  1  redirect request, one-cycle pulse.
- branch_target  in  PC_W  redirect address.
- halt_req  in  1  stop fetching, level.
- halted  out  1  state == HALTED.

Behaviour:
- Reset (async assert, takes effect immediately):
  - pc = RESET_PC; ir_out = 0; ir_pc = 0; ir_valid = 0; state = BOOT; halted = 0.
- States: BOOT, RUN, HALTED.
  - BOOT: one cycle after reset release with no fetch; then -> RUN. This gives the ROM address one settle cycle.
  - RUN: a fetch occurs when load = (!ir_valid || dec_ready).
    - On load: ir_out <= rom_instr; ir_pc <= pc; ir_valid <= 1; pc <= pc+1.
    - PC arithmetic is modulo 2^PC_W.
  - RUN, no load (ir_valid=1, dec_ready=0): stall. IR, ir_pc, ir_valid and pc hold.
  - RUN -> HALTED when halt_req=1 (and no branch that cycle).
    - That cycle performs no new fetch.
    - A pending IR still completes its handshake: ir_valid drops when dec_ready=1.
  - RUN, WRAP_EN=0, load with pc = 2^PC_W-1: IR loads normally, pc holds at the last address, then -> HALTED.
  - HALTED: no fetch; pc holds.
    - halt_req deassert alone does not resume.
    - branch_en=1 resumes: pc <= branch_target, ir_valid <= 0, -> RUN.
- Branch priority (any state except BOOT): branch_en overrides load, stall and halt_req.
  - pc <= branch_target; ir_valid <= 0 (flush of the unconsumed IR).
  - Next fetch loads from branch_target one cycle later.
  - Branch in BOOT is ignored.
- Handshake:
  - Decode consumes IR on the cycle where ir_valid && dec_ready.
  - Back-to-back consumption sustains 1 instruction/cycle.
  - ir_out is stable while ir_valid=1 and dec_ready=0.
- Latency:
  - First ir_valid=1 is on the 2nd rising edge after reset release (BOOT edge + fetch edge).
  - Branch-to-target valid latency is 2 edges.
- Outputs: all are registered except rom_addr (= pc register) and halted (decoded from the state register).

Test Plan:
- Reset release, dec_ready=1, ROM[0]=16'h1C0A, ROM[1..7]=16'hFC00:
  - edge1: ir_valid=0.
  - edge2: ir_out=1C0A, ir_pc=0.
  - edges 3–9: FC00 with ir_pc 1..7.
  - edge10 (WRAP_EN=1): ir_pc=0, ir_out=1C0A.
- Stall:
  - dec_ready=0 for 3 cycles after IR=ROM[2] -> ir_out, ir_pc=2 and rom_addr=3 hold.
  - Release -> ROM[3] next edge.
- Branch: branch_en with target=5 while IR holds ROM[1] and dec_ready=0 -> ir_valid=0 next edge; ir_pc=5 on the following edge.
- Halt:
  - halt_req while ir_valid=1, dec_ready=0 -> halted=1, IR held.
  - dec_ready=1 -> ir_valid=0, pc unchanged.
  - branch_en target=0 -> RUN, ROM[0] fetched.
- WRAP_EN=0: free-run from 0 -> after ir_pc=7, halted=1, rom_addr=7, no further ir_valid.
- Async reset mid-run (pc=4, ir_valid=1), asserted between edges -> pc=0, ir_valid=0, ir_out=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, instruction register, valid/ready hand-off to decode
// Branch redirect flushes the IR; halt and end-of-ROM stop fetching until a branch resumes.
module instr_fetch #(
    parameter int PC_W     = 3,
    parameter int INSTR_W  = 16,
    parameter bit WRAP_EN  = 1'b1,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_instr,
    output logic [INSTR_W-1:0] ir_out,
    output logic [PC_W-1:0]    ir_pc,
    output logic               ir_valid,
    input  logic               dec_ready,
    input  logic               branch_en,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt_req,
    output logic               halted
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_LAST = {PC_W{1'b1}};

    state_t            state;
    state_t            next_state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_next;
    logic              valid_next;
    logic              load_ir;
    logic              consume;

    assign rom_addr = pc;
    assign halted   = (state == HALTED);
    assign consume  = ir_valid && dec_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pc_next    = pc;
        valid_next = ir_valid;
        load_ir    = 1'b0;
        case (state)
            BOOT: begin
                next_state = RUN;
            end
            RUN: begin
                if (branch_en) begin
                    pc_next    = branch_target;
                    valid_next = 1'b0;
                end else if (halt_req) begin
                    // No new fetch, but a pending IR may still be consumed.
                    next_state = HALTED;
                    if (consume) begin
                        valid_next = 1'b0;
                    end
                end else if (!ir_valid || dec_ready) begin
                    load_ir    = 1'b1;
                    valid_next = 1'b1;
                    if (!WRAP_EN && pc == PC_LAST) begin
                        next_state = HALTED;
                    end else begin
                        pc_next = pc + PC_W'(1);
                    end
                end
            end
            HALTED: begin
                if (branch_en) begin
                    pc_next    = branch_target;
                    valid_next = 1'b0;
                    next_state = RUN;
                end else if (consume) begin
                    valid_next = 1'b0;
                end
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= PC_W'(RESET_PC);
            ir_out   <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            pc       <= pc_next;
            ir_valid <= valid_next;
            if (load_ir) begin
                ir_out <= rom_instr;
                ir_pc  <= pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (wrapping and stop-at-end instances)
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rom [8];

    logic [2:0]  rom_addr, rom_addr_b;
    logic [15:0] rom_instr, rom_instr_b;
    logic [15:0] ir_out, ir_out_b;
    logic [2:0]  ir_pc, ir_pc_b;
    logic        ir_valid, ir_valid_b;
    logic        halted, halted_b;
    logic        dec_ready = 1'b0;
    logic        branch_en = 1'b0;
    logic [2:0]  branch_target = 3'd0;
    logic        halt_req = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model of the wrapping instance
    bit          m_boot;
    bit          m_halted;
    logic [2:0]  m_pc;
    logic [15:0] m_ir;
    logic [2:0]  m_irpc;
    bit          m_valid;

    always #5 clk = ~clk;

    assign rom_instr   = rom[rom_addr];
    assign rom_instr_b = rom[rom_addr_b];

    instr_fetch #(.PC_W(3), .INSTR_W(16), .WRAP_EN(1'b1), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_instr(rom_instr),
        .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .dec_ready(dec_ready),
        .branch_en(branch_en), .branch_target(branch_target), .halt_req(halt_req),
        .halted(halted)
    );

    instr_fetch #(.PC_W(3), .INSTR_W(16), .WRAP_EN(1'b0), .RESET_PC(0)) dut_b (
        .clk(clk), .rst(rst), .rom_addr(rom_addr_b), .rom_instr(rom_instr_b),
        .ir_out(ir_out_b), .ir_pc(ir_pc_b), .ir_valid(ir_valid_b), .dec_ready(dec_ready),
        .branch_en(branch_en), .branch_target(branch_target), .halt_req(halt_req),
        .halted(halted_b)
    );

    task automatic model_reset();
        m_boot = 1; m_halted = 0; m_pc = 0; m_ir = 0; m_irpc = 0; m_valid = 0;
    endtask

    task automatic model_step();
        if (m_boot) begin
            m_boot = 0;
        end else if (branch_en) begin
            m_pc = branch_target; m_valid = 0; m_halted = 0;
        end else if (m_halted || halt_req) begin
            m_halted = 1;
            if (m_valid && dec_ready) m_valid = 0;
        end else if (!m_valid || dec_ready) begin
            m_ir = rom[m_pc]; m_irpc = m_pc; m_valid = 1;
            m_pc = 3'((int'(m_pc) + 1) % 8);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; dec_ready = 0; branch_en = 0; halt_req = 0; branch_target = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ir_valid); end
        checks++; if (ir_out !== 16'h0) begin errors++; $display("FAIL reset_ir got %h want 0000", ir_out); end
        checks++; if (ir_pc !== 3'd0) begin errors++; $display("FAIL reset_irpc got %0d want 0", ir_pc); end
        checks++; if (rom_addr !== 3'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", rom_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
    endtask

    task automatic test_sequence();
        rom[0] = 16'h1C0A;
        for (int i = 1; i < 8; i++) rom[i] = 16'hFC00;
        reset_dut();
        dec_ready = 1;
        tick();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %0b want 0", ir_valid); end
        tick();
        checks++; if (ir_valid !== 1'b1 || ir_out !== 16'h1C0A || ir_pc !== 3'd0)
            begin errors++; $display("FAIL first_fetch got v=%0b %h pc=%0d want v=1 1c0a pc=0", ir_valid, ir_out, ir_pc); end
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++; if (ir_valid !== 1'b1 || ir_out !== 16'hFC00 || ir_pc !== 3'(i))
                begin errors++; $display("FAIL seq_fetch got v=%0b %h pc=%0d want v=1 fc00 pc=%0d", ir_valid, ir_out, ir_pc, i); end
        end
        tick();
        checks++; if (ir_out !== 16'h1C0A || ir_pc !== 3'd0)
            begin errors++; $display("FAIL wrap_fetch got %h pc=%0d want 1c0a pc=0", ir_out, ir_pc); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) rom[i] = 16'h1000 + 16'(i * 16'h0111);
        reset_dut();
        dec_ready = 1;
        repeat (4) tick();
        checks++; if (ir_pc !== 3'd2) begin errors++; $display("FAIL stall_pre got pc=%0d want 2", ir_pc); end
        dec_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (ir_valid !== 1'b1 || ir_pc !== 3'd2 || ir_out !== rom[2] || rom_addr !== 3'd3)
                begin errors++; $display("FAIL stall_hold got v=%0b pc=%0d %h addr=%0d want v=1 pc=2 %h addr=3", ir_valid, ir_pc, ir_out, rom_addr, rom[2]); end
        end
        dec_ready = 1;
        tick();
        checks++; if (ir_pc !== 3'd3 || ir_out !== rom[3])
            begin errors++; $display("FAIL stall_release got pc=%0d %h want pc=3 %h", ir_pc, ir_out, rom[3]); end
    endtask

    task automatic test_branch();
        reset_dut();
        dec_ready = 1;
        repeat (3) tick();
        checks++; if (ir_pc !== 3'd1) begin errors++; $display("FAIL branch_pre got pc=%0d want 1", ir_pc); end
        dec_ready = 0; branch_en = 1; branch_target = 3'd5;
        tick();
        branch_en = 0;
        checks++; if (ir_valid !== 1'b0 || rom_addr !== 3'd5)
            begin errors++; $display("FAIL branch_flush got v=%0b addr=%0d want v=0 addr=5", ir_valid, rom_addr); end
        tick();
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 3'd5 || ir_out !== rom[5])
            begin errors++; $display("FAIL branch_target got v=%0b pc=%0d %h want v=1 pc=5 %h", ir_valid, ir_pc, ir_out, rom[5]); end
    endtask

    task automatic test_halt();
        reset_dut();
        dec_ready = 1;
        repeat (2) tick();
        dec_ready = 0; halt_req = 1;
        tick();
        checks++; if (halted !== 1'b1 || ir_valid !== 1'b1 || ir_pc !== 3'd0 || rom_addr !== 3'd1)
            begin errors++; $display("FAIL halt_enter got h=%0b v=%0b pc=%0d addr=%0d want h=1 v=1 pc=0 addr=1", halted, ir_valid, ir_pc, rom_addr); end
        dec_ready = 1;
        tick();
        checks++; if (ir_valid !== 1'b0 || rom_addr !== 3'd1 || halted !== 1'b1)
            begin errors++; $display("FAIL halt_drain got v=%0b addr=%0d h=%0b want v=0 addr=1 h=1", ir_valid, rom_addr, halted); end
        halt_req = 0;
        tick();
        checks++; if (halted !== 1'b1 || ir_valid !== 1'b0)
            begin errors++; $display("FAIL halt_sticky got h=%0b v=%0b want h=1 v=0", halted, ir_valid); end
        branch_en = 1; branch_target = 3'd0;
        tick();
        branch_en = 0;
        checks++; if (halted !== 1'b0 || rom_addr !== 3'd0)
            begin errors++; $display("FAIL halt_resume got h=%0b addr=%0d want h=0 addr=0", halted, rom_addr); end
        tick();
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 3'd0 || ir_out !== rom[0])
            begin errors++; $display("FAIL halt_refetch got v=%0b pc=%0d %h want v=1 pc=0 %h", ir_valid, ir_pc, ir_out, rom[0]); end
    endtask

    task automatic test_nowrap();
        reset_dut();
        dec_ready = 1;
        repeat (9) tick();
        checks++; if (ir_pc_b !== 3'd7 || ir_valid_b !== 1'b1 || halted_b !== 1'b1 || rom_addr_b !== 3'd7)
            begin errors++; $display("FAIL nowrap_end got pc=%0d v=%0b h=%0b addr=%0d want pc=7 v=1 h=1 addr=7", ir_pc_b, ir_valid_b, halted_b, rom_addr_b); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (ir_valid_b !== 1'b0 || halted_b !== 1'b1 || rom_addr_b !== 3'd7)
                begin errors++; $display("FAIL nowrap_stop got v=%0b h=%0b addr=%0d want v=0 h=1 addr=7", ir_valid_b, halted_b, rom_addr_b); end
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        dec_ready = 1;
        repeat (5) tick();
        checks++; if (rom_addr !== 3'd4 || ir_valid !== 1'b1)
            begin errors++; $display("FAIL arst_pre got addr=%0d v=%0b want addr=4 v=1", rom_addr, ir_valid); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (rom_addr !== 3'd0 || ir_valid !== 1'b0 || ir_out !== 16'h0 || ir_pc !== 3'd0)
            begin errors++; $display("FAIL arst_now got addr=%0d v=%0b %h pc=%0d want 0 0 0000 0", rom_addr, ir_valid, ir_out, ir_pc); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) rom[i] = 16'($urandom);
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            branch_en = ($urandom_range(0, 7) == 0);
            branch_target = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
            tick();
            checks++; if (ir_valid !== m_valid || rom_addr !== m_pc || halted !== m_halted ||
                          (m_valid && (ir_out !== m_ir || ir_pc !== m_irpc)))
                begin errors++; $display("FAIL random c=%0d got v=%0b addr=%0d h=%0b %h pc=%0d want v=%0b addr=%0d h=%0b %h pc=%0d",
                    c, ir_valid, rom_addr, halted, ir_out, ir_pc, m_valid, m_pc, m_halted, m_ir, m_irpc); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = 16'h0;
        model_reset();
        test_reset();
        test_sequence();
        test_stall();
        test_branch();
        test_halt();
        test_nowrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
